// File: rtl/selector_overlay.sv
// Selector box overlay: frame-synchronous position update,
// two-stage pixel pipeline against an external 66x59 shape ROM.
module selector_overlay (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        pix_valid,
   input  logic [10:0] pix_x,
   input  logic [9:0]  pix_y,
   input  logic        pos_valid,
   output logic        pos_ready,
   input  logic [10:0] pos_x,
   input  logic [9:0]  pos_y,
   input  logic        blink_en,
   output logic [6:0]  rom_address,
   input  logic [58:0] rom_data,
   output logic        out_valid,
   output logic        out_on
);

   localparam logic [0:0] S_IDLE    = 1'b0;
   localparam logic [0:0] S_PENDING = 1'b1;

   localparam logic [10:0] BOX_W = 11'd59;
   localparam logic [10:0] BOX_H = 11'd66;

   logic [0:0]  state;
   logic [10:0] pend_x;
   logic [9:0]  pend_y;
   logic [10:0] cur_x;
   logic [9:0]  cur_y;
   logic [4:0]  frame_cnt;

   logic [10:0] dx;
   logic [10:0] dy;
   logic        hit0;

   logic        vld1;
   logic        hit1;
   logic [5:0]  col1;
   logic [5:0]  bit_idx;
   logic        visible;

   assign pos_ready = (state == S_IDLE);

   // Offsets are only meaningful when the ">=" terms hold,
   // so the subtraction never needs to wrap.
   assign dx = pix_x - cur_x;
   assign dy = {1'b0, pix_y} - {1'b0, cur_y};

   assign hit0 = pix_valid
               & (pix_x >= cur_x)
               & (dx < BOX_W)
               & (pix_y >= cur_y)
               & (dy < BOX_H);

   assign bit_idx = 6'd58 - col1;
   assign visible = ~blink_en | ~frame_cnt[4];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         pend_x <= '0;
         pend_y <= '0;
         cur_x  <= '0;
         cur_y  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pos_valid) begin
                  pend_x <= pos_x;
                  pend_y <= pos_y;
                  state  <= S_PENDING;
               end
            end
            S_PENDING: begin
               if (frame_start) begin
                  cur_x <= pend_x;
                  cur_y <= pend_y;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if (frame_start) begin
         frame_cnt <= frame_cnt + 5'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld1        <= 1'b0;
         hit1        <= 1'b0;
         col1        <= '0;
         rom_address <= '0;
      end else begin
         vld1        <= pix_valid;
         hit1        <= hit0;
         col1        <= hit0 ? dx[5:0] : 6'd0;
         rom_address <= hit0 ? dy[6:0] : 7'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_on    <= 1'b0;
      end else begin
         out_valid <= vld1;
         out_on    <= hit1 & rom_data[bit_idx] & visible;
      end
   end

endmodule

// File: tb/tb_selector_overlay.sv
// Directed self-checking bench for selector_overlay with a
// behavioural shape ROM.
module tb_selector_overlay;

   logic        clk;
   logic        rst_n;
   logic        frame_start;
   logic        pix_valid;
   logic [10:0] pix_x;
   logic [9:0]  pix_y;
   logic        pos_valid;
   logic        pos_ready;
   logic [10:0] pos_x;
   logic [9:0]  pos_y;
   logic        blink_en;
   logic [6:0]  rom_address;
   logic [58:0] rom_data;
   logic        out_valid;
   logic        out_on;

   int tests;
   int fails;
   int fc;

   selector_overlay dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_start (frame_start),
      .pix_valid   (pix_valid),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .pos_valid   (pos_valid),
      .pos_ready   (pos_ready),
      .pos_x       (pos_x),
      .pos_y       (pos_y),
      .blink_en    (blink_en),
      .rom_address (rom_address),
      .rom_data    (rom_data),
      .out_valid   (out_valid),
      .out_on      (out_on)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shape: row 17 fully lit, row 65 cols 26..28, other rows cols 26..32.
   function automatic logic [58:0] shape(input logic [6:0] r);
      logic [58:0] v;
      v = '0;
      for (int c = 0; c < 59; c++) begin
         if (r == 7'd17)
            v[58-c] = 1'b1;
         else if (r == 7'd65)
            v[58-c] = (c >= 26 && c <= 28);
         else
            v[58-c] = (c >= 26 && c <= 32);
      end
      return v;
   endfunction

   always_comb rom_data = shape(rom_address);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      fc = fc + 1;
   endtask

   task automatic set_pos(input logic [10:0] x, input logic [9:0] y);
      pos_valid = 1'b1;
      pos_x = x;
      pos_y = y;
      step();
      pos_valid = 1'b0;
   endtask

   task automatic probe(input logic [10:0] x, input logic [9:0] y,
                        output logic v, output logic on);
      pix_valid = 1'b1;
      pix_x = x;
      pix_y = y;
      step();
      pix_valid = 1'b0;
      step();
      v = out_valid;
      on = out_on;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) step();
      tests++;
      if (pos_ready !== 1'b1 || out_valid !== 1'b0 || out_on !== 1'b0
          || rom_address !== 7'd0) begin
         fails++;
         $display("FAIL reset: ready=%b valid=%b on=%b addr=%0d, need 1 0 0 0",
                  pos_ready, out_valid, out_on, rom_address);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_geometry();
      logic v, on;
      logic [10:0] xs [4] = '{11'd126, 11'd125, 11'd132, 11'd133};
      logic        ex [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      set_pos(11'd100, 10'd50);
      frame();
      for (int i = 0; i < 4; i++) begin
         probe(xs[i], 10'd50, v, on);
         tests++;
         if (v !== 1'b1 || on !== ex[i]) begin
            fails++;
            $display("FAIL geometry x=%0d: valid=%b on=%b, need 1 %b",
                     xs[i], v, on, ex[i]);
         end
      end
   endtask

   task automatic test_edges();
      logic v, on;
      logic [10:0] xs [6] = '{11'd100, 11'd158, 11'd159,
                              11'd129, 11'd126, 11'd126};
      logic [9:0]  ys [6] = '{10'd67, 10'd67, 10'd67,
                              10'd115, 10'd115, 10'd116};
      logic        ex [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         probe(xs[i], ys[i], v, on);
         tests++;
         if (v !== 1'b1 || on !== ex[i]) begin
            fails++;
            $display("FAIL edge (%0d,%0d): valid=%b on=%b, need 1 %b",
                     xs[i], ys[i], v, on, ex[i]);
         end
      end
   endtask

   task automatic test_handshake();
      logic v, on;
      set_pos(11'd10, 10'd10);
      tests++;
      if (pos_ready !== 1'b0) begin
         fails++;
         $display("FAIL hs_busy: ready=%b, need 0", pos_ready);
      end
      pos_valid = 1'b1;
      pos_x = 11'd20;
      pos_y = 10'd20;
      repeat (3) step();
      frame();
      pos_valid = 1'b1;
      tests++;
      if (pos_ready !== 1'b1) begin
         fails++;
         $display("FAIL hs_ready_after_frame: ready=%b, need 1", pos_ready);
      end
      step();
      pos_valid = 1'b0;
      tests++;
      if (pos_ready !== 1'b0) begin
         fails++;
         $display("FAIL hs_second_accept: ready=%b, need 0", pos_ready);
      end
      probe(11'd36, 10'd10, v, on);
      tests++;
      if (v !== 1'b1 || on !== 1'b1) begin
         fails++;
         $display("FAIL hs_box_10: valid=%b on=%b, need 1 1", v, on);
      end
      probe(11'd46, 10'd30, v, on);
      tests++;
      if (v !== 1'b1 || on !== 1'b0) begin
         fails++;
         $display("FAIL hs_not_20_yet: valid=%b on=%b, need 1 0", v, on);
      end
      frame();
      probe(11'd46, 10'd30, v, on);
      tests++;
      if (v !== 1'b1 || on !== 1'b1) begin
         fails++;
         $display("FAIL hs_box_20: valid=%b on=%b, need 1 1", v, on);
      end
   endtask

   task automatic test_simultaneous();
      logic v, on;
      pos_valid = 1'b1;
      pos_x = 11'd300;
      pos_y = 10'd200;
      frame();
      pos_valid = 1'b0;
      tests++;
      if (pos_ready !== 1'b0) begin
         fails++;
         $display("FAIL sim_accept: ready=%b, need 0", pos_ready);
      end
      probe(11'd46, 10'd30, v, on);
      tests++;
      if (on !== 1'b1) begin
         fails++;
         $display("FAIL sim_old_box: on=%b, need 1", on);
      end
      probe(11'd326, 10'd200, v, on);
      tests++;
      if (on !== 1'b0) begin
         fails++;
         $display("FAIL sim_not_moved: on=%b, need 0", on);
      end
      frame();
      probe(11'd326, 10'd200, v, on);
      tests++;
      if (on !== 1'b1) begin
         fails++;
         $display("FAIL sim_moved: on=%b, need 1", on);
      end
      probe(11'd46, 10'd30, v, on);
      tests++;
      if (on !== 1'b0) begin
         fails++;
         $display("FAIL sim_old_gone: on=%b, need 0", on);
      end
   endtask

   task automatic test_blink();
      logic v, on;
      int   chk [5] = '{0, 15, 16, 31, 32};
      logic ex  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      int   base;
      blink_en = 1'b1;
      while (fc % 32 != 0) frame();
      base = fc;
      for (int i = 0; i < 5; i++) begin
         while (fc - base < chk[i]) frame();
         probe(11'd326, 10'd200, v, on);
         tests++;
         if (v !== 1'b1 || on !== ex[i]) begin
            fails++;
            $display("FAIL blink frame %0d: valid=%b on=%b, need 1 %b",
                     chk[i], v, on, ex[i]);
         end
      end
      blink_en = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic v, on;
      set_pos(11'd500, 10'd400);
      pix_valid = 1'b1;
      pix_x = 11'd326;
      pix_y = 10'd200;
      step();
      rst_n = 1'b0;
      #1;
      pix_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b0 || out_on !== 1'b0 || pos_ready !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid: valid=%b on=%b ready=%b, need 0 0 1",
                  out_valid, out_on, pos_ready);
      end
      step();
      rst_n = 1'b1;
      fc = 0;
      step();
      probe(11'd26, 10'd0, v, on);
      tests++;
      if (v !== 1'b1 || on !== 1'b1) begin
         fails++;
         $display("FAIL rst_box_origin: valid=%b on=%b, need 1 1", v, on);
      end
      frame();
      probe(11'd26, 10'd0, v, on);
      tests++;
      if (on !== 1'b1) begin
         fails++;
         $display("FAIL rst_pending_dropped: on=%b, need 1", on);
      end
   endtask

   task automatic test_back_to_back();
      logic [10:0] xs [10] = '{11'd24, 11'd25, 11'd26, 11'd27, 11'd28,
                               11'd30, 11'd31, 11'd32, 11'd33, 11'd34};
      logic        vs [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic        eo [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int c = 0; c < 12; c++) begin
         if (c < 10) begin
            pix_valid = vs[c];
            pix_x = xs[c];
            pix_y = 10'd0;
         end else begin
            pix_valid = 1'b0;
         end
         step();
         if (c >= 1 && c <= 10) begin
            tests++;
            if (out_valid !== vs[c-1] || out_on !== eo[c-1]) begin
               fails++;
               $display("FAIL b2b[%0d]: valid=%b on=%b, need %b %b",
                        c - 1, out_valid, out_on, vs[c-1], eo[c-1]);
            end
         end
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      fc = 0;
      rst_n = 1'b0;
      frame_start = 1'b0;
      pix_valid = 1'b0;
      pix_x = '0;
      pix_y = '0;
      pos_valid = 1'b0;
      pos_x = '0;
      pos_y = '0;
      blink_en = 1'b0;
      #2;
      test_reset();
      test_geometry();
      test_edges();
      test_handshake();
      test_simultaneous();
      test_blink();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
